uart_baud_scanner: RTL
======================

# uart_baud_scanner

Auto-baud controller for the UART receiver. It steps the receiver's 3-bit baud select through the five supported rates, flushing the receiver at each change, until a run of parity-clean frames arrives. It then locks, forwards received bytes, and rescans if the link degrades. It sits between the receiver top level and the user logic, in the 50 MHz clock domain.

## Interface
- TIMEOUT_CYC, 2000000: clk cycles in LISTEN with no frame before advancing the rate.
- GOOD_FRAMES, 3: consecutive parity-clean frames required to lock.
- LOSS_ERRS, 4: consecutive parity-bad frames in LOCKED that force a rescan.
- FLUSH_CYC, 16: clk cycles that rx_flush is held high on each rate change.
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 runs the scanner, 0 parks it in IDLE.
- frame_tgl  in  1  toggles once per completed receiver frame; launched from the receiver's derived clock.
- parity_ok  in  1  receiver parity result; stable whenever frame_tgl is stable.
- rx_data  in  8  receiver byte; stable whenever frame_tgl is stable.
- BC  out  3  baud select to the receiver. Codes 0..4 are 9600, 19200, 38400, 57600 and 115200.
- rx_flush  out  1  active-high receiver flush.
- locked  out  1  rate acquired.
- data_out  out  8  last good byte received while locked.
- data_valid  out  1  one-cycle strobe, asserted when data_out updates.

## Operation
- Input capture: frame_tgl passes through a 2-flop synchronizer. A frame event is a 1-cycle pulse generated when the synchronized value differs from its previous value.
- parity_ok and rx_data are captured into holding registers in the cycle the frame event is generated.
- States:
  - IDLE: default state.
  - FLUSH: asserts rx_flush.
  - LISTEN: counts good frames toward lock.
  - LOCKED: forwards good bytes.
- IDLE -> FLUSH when enable=1.
- FLUSH -> LISTEN after FLUSH_CYC cycles. Frame events are ignored in FLUSH.
- LISTEN transitions:
  - Good frame: good_cnt increments. When good_cnt reaches GOOD_FRAMES, go to LOCKED with locked=1.
  - Bad frame: advance the rate, go to FLUSH, clear good_cnt.
  - Timeout: the timeout counter reaches TIMEOUT_CYC-1 with no frame. Advance the rate and go to FLUSH.
  - The timeout counter clears on every frame event and on every entry to LISTEN.
- LOCKED transitions:
  - Good frame: data_out <= captured byte; data_valid pulses; bad_cnt clears.
  - Bad frame: bad_cnt increments. When bad_cnt reaches LOSS_ERRS, set locked=0, advance the rate, go to FLUSH.
  - No timeout applies in LOCKED; an idle line keeps the lock.
- Rate advance: BC <= (BC==4) ? 0 : BC+1. Codes 5..7 are never driven.
- enable=0 in any state: go to IDLE on the next cycle. Counters clear and locked clears; BC holds its value.
- Simultaneous frame event and timeout in LISTEN: the frame event takes priority.
- Counter widths:
  - Timeout counter: $clog2(TIMEOUT_CYC).
  - good_cnt and bad_cnt: $clog2(max+1).
  - All counters are unsigned and never wrap past their threshold.

## Timing
- Reset values:
  - Outputs: BC=0, rx_flush=0, locked=0, data_out=8'h00, data_valid=0.
  - Internals: state=IDLE, all counters 0.
- rx_flush is registered. It is high for exactly FLUSH_CYC cycles, beginning the cycle after FLUSH is entered.
- BC changes in the same cycle that FLUSH is entered, so it is stable for the whole flush.
- Latency from a frame_tgl edge to the frame event is 2–3 clk cycles. data_valid and locked update 1 cycle after the frame event.
- Reset asserted mid-operation: all state clears immediately. After reset releases, with enable=1, FLUSH is entered on the first clk edge.

## Configuration
- BAUD_SCAN_STATS_EN defined: adds two outputs.
  - err_cnt [15:0]: counts bad frames in LISTEN and LOCKED.
  - relock_cnt [15:0]: counts LOCKED -> FLUSH transitions.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Macro undefined: neither port nor the counter logic exists, and all other behaviour is identical.

## Structure
- Shared package uart_ctrl_pkg contains:
  - the state enum (IDLE, FLUSH, LISTEN, LOCKED);
  - BC code constants BC_9600..BC_115200;
  - NUM_RATES=5.
- Sub-module uart_tgl_sync: the 2-flop synchronizer plus toggle-to-pulse detector, with a reset to 0.

## Test plan
- Use TIMEOUT_CYC=100 for all scenarios.
- enable=1 with three good frames at BC=0 -> FLUSH of 16 cycles, then locked=1 after the third frame event; BC stays 0.
- Bad frame at BC=0, then three good frames -> BC=1, rx_flush pulses 16 cycles, then locked=1 with BC=1.
- No frames at BC=4 -> after 100 LISTEN cycles BC wraps to 0 and FLUSH is re-entered.
- Locked, then 4 consecutive bad frames -> locked=0 and BC advances by one. A good frame between bad frames resets bad_cnt and no unlock occurs.
- Locked, good frame with rx_data=8'hA5 -> data_out=8'hA5 and a single-cycle data_valid.
- Reset pulled low mid-FLUSH, or enable dropped while LOCKED -> outputs take reset values, or IDLE with BC held, respectively. With BAUD_SCAN_STATS_EN, err_cnt and relock_cnt match the injected event counts.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART auto-baud control logic: scanner states,
// baud-select codes and the rate-advance helper.
package uart_ctrl_pkg;

    // Scanner states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        LISTEN = 2'd2,
        LOCKED = 2'd3
    } state_e;

    // Baud-select codes understood by the receiver
    localparam logic [2:0] BC_9600   = 3'd0;
    localparam logic [2:0] BC_19200  = 3'd1;
    localparam logic [2:0] BC_38400  = 3'd2;
    localparam logic [2:0] BC_57600  = 3'd3;
    localparam logic [2:0] BC_115200 = 3'd4;

    localparam int NUM_RATES = 5;

    // Next rate in the scan order, wrapping from the fastest back to the slowest.
    // Codes above the last valid rate also fall back to the slowest.
    function automatic logic [2:0] next_rate(input logic [2:0] bc);
        if (bc >= 3'(NUM_RATES - 1)) begin
            return BC_9600;
        end
        return bc + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tgl_sync.sv
// Brings the receiver's frame toggle into the clk domain through a 2-flop
// synchronizer and turns each toggle into a single-cycle event pulse.
module uart_tgl_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds a real shift chain.
            sync1_q <= tgl_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q ^ prev_q;

endmodule

// File: rtl/uart_baud_scanner.sv
// Auto-baud scanner: steps the receiver baud select through the supported
// rates, flushing the receiver on every change, until GOOD_FRAMES consecutive
// parity-clean frames arrive; then locks and forwards bytes until LOSS_ERRS
// consecutive parity errors force a rescan.
// Optional build macro BAUD_SCAN_STATS_EN adds saturating err_cnt/relock_cnt.
module uart_baud_scanner
    import uart_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2000000,
    parameter int GOOD_FRAMES = 3,
    parameter int LOSS_ERRS   = 4,
    parameter int FLUSH_CYC   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tgl,
    input  logic       parity_ok,
    input  logic [7:0] rx_data,
    output logic [2:0] BC,
    output logic       rx_flush,
    output logic       locked,
    output logic [7:0] data_out,
    output logic       data_valid
`ifdef BAUD_SCAN_STATS_EN
    ,
    output logic [15:0] err_cnt,
    output logic [15:0] relock_cnt
`endif
);

    localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GOOD_W  = $clog2(GOOD_FRAMES + 1);
    localparam int BAD_W   = $clog2(LOSS_ERRS + 1);
    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e             state_q, state_d;
    logic [2:0]         bc_q, bc_d;
    logic               flush_q, flush_d;
    logic               locked_q, locked_d;
    logic [7:0]         dout_q, dout_d;
    logic               dv_q, dv_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic [FLUSH_W-1:0] fcnt_q, fcnt_d;
    logic               par_q, par_d;
    logic [7:0]         byte_q, byte_d;
    logic               frame_ev;

    uart_tgl_sync u_tgl_sync (
        .clk     (clk),
        .rst_n   (reset),
        .tgl_i   (frame_tgl),
        .pulse_o (frame_ev)
    );

    // The holding registers load in the event cycle; the FSM decides on the
    // same edge, so it looks at the value being loaded rather than the stale one.
    assign par_d  = frame_ev ? parity_ok : par_q;
    assign byte_d = frame_ev ? rx_data   : byte_q;

    // Next-state, counter and output decisions for the scanner
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        bc_d     = bc_q;
        locked_d = locked_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        tmo_d    = tmo_q;
        good_d   = good_q;
        bad_d    = bad_q;
        fcnt_d   = fcnt_q;
        flush_d  = (state_q == FLUSH) && enable;

        if (!enable) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            tmo_d    = '0;
            good_d   = '0;
            bad_d    = '0;
            fcnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
                FLUSH: begin
                    if (fcnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                        state_d = LISTEN;
                        tmo_d   = '0;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FLUSH_W'(1);
                    end
                end
                LISTEN: begin
                    if (frame_ev) begin
                        tmo_d = '0;
                        if (par_d) begin
                            if (good_q == GOOD_W'(GOOD_FRAMES - 1)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                good_d   = '0;
                                bad_d    = '0;
                            end else begin
                                good_d = good_q + GOOD_W'(1);
                            end
                        end else begin
                            state_d = FLUSH;
                            bc_d    = next_rate(bc_q);
                            fcnt_d  = '0;
                            good_d  = '0;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_d = FLUSH;
                        bc_d    = next_rate(bc_q);
                        fcnt_d  = '0;
                        good_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                LOCKED: begin
                    if (frame_ev) begin
                        if (par_d) begin
                            dout_d = byte_d;
                            dv_d   = 1'b1;
                            bad_d  = '0;
                        end else if (bad_q == BAD_W'(LOSS_ERRS - 1)) begin
                            state_d  = FLUSH;
                            bc_d     = next_rate(bc_q);
                            locked_d = 1'b0;
                            fcnt_d   = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Scanner state, counters, holding registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bc_q     <= BC_9600;
            flush_q  <= 1'b0;
            locked_q <= 1'b0;
            dout_q   <= 8'h00;
            dv_q     <= 1'b0;
            tmo_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            fcnt_q   <= '0;
            par_q    <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            flush_q  <= flush_d;
            locked_q <= locked_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            tmo_q    <= tmo_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            fcnt_q   <= fcnt_d;
            par_q    <= par_d;
            byte_q   <= byte_d;
        end
    end

    assign BC         = bc_q;
    assign rx_flush   = flush_q;
    assign locked     = locked_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;

`ifdef BAUD_SCAN_STATS_EN
    logic        err_inc;
    logic        relock_inc;
    logic [15:0] err_cnt_q;
    logic [15:0] relock_cnt_q;

    assign err_inc    = enable && frame_ev && !par_d &&
                        ((state_q == LISTEN) || (state_q == LOCKED));
    assign relock_inc = enable && frame_ev && !par_d && (state_q == LOCKED) &&
                        (bad_q == BAD_W'(LOSS_ERRS - 1));

    // Saturating statistics; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q    <= 16'h0000;
            relock_cnt_q <= 16'h0000;
        end else begin
            if (err_inc && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (relock_inc && (relock_cnt_q != 16'hFFFF)) begin
                relock_cnt_q <= relock_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt    = err_cnt_q;
    assign relock_cnt = relock_cnt_q;
`endif

endmodule
